wb_port_arbiter: RTL and testbench

Shares the single write port of the integer register file between NREQ write-back requesters, for example the ALU, load unit and multi-cycle mul/div unit. Each requester uses a valid/ready handshake. The arbiter picks one requester per cycle in round-robin order. It registers the winning destination and data, then drives the register-file write port (rd, write_data, reg_write) for exactly one cycle per accepted transfer.

---
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 tb/tb_wb_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter sharing the single integer register-file
// write port between NREQ write-back requesters (ALU, load unit, mul/div, ...).
// A winner is picked combinationally each cycle, its destination and data are
// registered, and the register-file write strobe is driven for one cycle.
//
// Optional feature macro: WB_ZERO_GUARD_EN
//   defined   - writes to rd==0 are still accepted (handshake and pointer move)
//               but the write strobe is suppressed, keeping r0 hard-wired zero.
//   undefined - rd==0 is written like any other register.
module wb_port_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_rd,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic [AW-1:0]       wb_rd,
  output logic [DW-1:0]       wb_data,
  output logic                wb_write,
  output logic [IDW-1:0]      wb_id,
  output logic [7:0]          busy_cnt
);

  // Round-robin pointer: index of the most recently granted requester.
  logic [IDW-1:0] last;

  // Combinational arbitration result.
  logic           found;
  logic [IDW-1:0] grant_idx;
  logic [AW-1:0]  sel_rd;
  logic [DW-1:0]  sel_data;
  logic           zero_block;
  logic           multi;

  // Registered write strobe before the reset gate on the output.
  logic           write_q;

  // Search last+1, last+2, ... (mod NREQ) and take the first valid requester.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
    // Nothing is accepted while reset is held; requesters re-present later.
    if (rst) begin
      found = 1'b0;
    end
  end

  // One-hot ready toward the granted requester, zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (found && (grant_idx == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // Payload of the winning requester.
  assign sel_rd   = req_rd[int'(grant_idx)*AW +: AW];
  assign sel_data = req_data[int'(grant_idx)*DW +: DW];

  // Contention: two or more requesters presenting in the same cycle.
  assign multi = ($countones(req_valid) >= 2);

`ifdef WB_ZERO_GUARD_EN
  // r0 is architecturally zero: accept the transfer but never strobe it.
  assign zero_block = (sel_rd == '0);
`else
  assign zero_block = 1'b0;
`endif

  // Registered write-back stage, round-robin pointer and contention counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      write_q  <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_id    <= '0;
      last     <= IDW'(NREQ - 1);
      busy_cnt <= '0;
    end else begin
      write_q <= found && !zero_block;
      if (found) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
        wb_id   <= grant_idx;
        last    <= grant_idx;
      end
      if (multi && (busy_cnt != 8'hFF)) begin
        busy_cnt <= busy_cnt + 8'd1;
      end
    end
  end

  // A pending write is dropped as soon as reset is raised, not one cycle late.
  assign wb_write = write_q & ~rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter with
// NREQ=3, AW=5, DW=32. A small register-file model captures the write port so
// read-back of the architectural result can be checked.
module tb_wb_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_rd;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       wb_rd;
  logic [DW-1:0]       wb_data;
  logic                wb_write;
  logic [IDW-1:0]      wb_id;
  logic [7:0]          busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] rf [0:31];

  wb_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_write  (wb_write),
    .wb_id     (wb_id),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed from the write port.
  always @(posedge clk) begin
    if (wb_write) rf[wb_rd] <= wb_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  initial begin
    int cnt0, cnt2, bad;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_zero_write;

    for (int r = 0; r < 32; r++) rf[r] = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    tick();
    tick();

    // Reset: ready suppressed even with all requesters valid.
    req_valid = 3'b111;
    #1;
    check("rst_ready_zero", req_ready, 0);
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("rst_wb_write", wb_write, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_wb_id", wb_id, 0);
    check("rst_busy_cnt", busy_cnt, 0);

    // 1: single request, one-cycle latency, single-cycle strobe.
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    check("t1_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check("t1_wb_write", wb_write, 1);
    check("t1_wb_rd", wb_rd, 5);
    check("t1_wb_data", wb_data, 32'hDEADBEEF);
    check("t1_wb_id", wb_id, 0);
    tick();
    check("t1_wb_write_off", wb_write, 0);
    check("t1_wb_rd_hold", wb_rd, 5);

    // 2: all three valid for six cycles after reset -> 0,1,2,0,1,2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 5'd1, 32'hA0);
    set_req(1, 5'd2, 32'hA1);
    set_req(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("t2_ready_c%0d", c), req_ready, 3'b001 << (c % 3));
      tick();
      check($sformatf("t2_wb_write_c%0d", c), wb_write, 1);
      check($sformatf("t2_wb_id_c%0d", c), wb_id, c % 3);
      check($sformatf("t2_wb_data_c%0d", c), wb_data, 32'hA0 + (c % 3));
    end
    req_valid = '0;
    check("t2_busy_cnt", busy_cnt, 6);
    tick();
    check("t2_wb_write_off", wb_write, 0);

    // 3: requesters 1 then 2 both target r7; the later grant wins.
    set_req(1, 5'd7, 32'h11);
    set_req(2, 5'd7, 32'h22);
    req_valid = 3'b110;
    #1;
    check("t3_ready_first", req_ready, 3'b010);
    tick();
    req_valid = 3'b100;
    #1;
    check("t3_ready_second", req_ready, 3'b100);
    check("t3_first_data", wb_data, 32'h11);
    tick();
    req_valid = '0;
    check("t3_second_data", wb_data, 32'h22);
    tick();
    check("t3_r7", rf[7], 32'h22);

    // 4: requesters 0 and 2 held for 300 cycles -> strict alternation, saturation.
    set_req(0, 5'd10, 32'h100);
    set_req(2, 5'd12, 32'h102);
    req_valid = 3'b101;
    cnt0 = 0;
    cnt2 = 0;
    bad  = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      exp_rdy = (c % 2 == 0) ? 3'b001 : 3'b100;
      if (req_ready !== exp_rdy) bad++;
      if (req_ready === 3'b001) cnt0++;
      if (req_ready === 3'b100) cnt2++;
      tick();
    end
    req_valid = '0;
    check("t4_alt_errors", bad, 0);
    check("t4_grants_r0", cnt0, 150);
    check("t4_grants_r2", cnt2, 150);
    check("t4_busy_sat", busy_cnt, 255);

    // 5: grant, then reset in the following cycle drops the pending write.
    set_req(1, 5'd9, 32'h55);
    req_valid = 3'b010;
    #1;
    check("t5_ready", req_ready, 3'b010);
    tick();
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    check("t5_write_dropped", wb_write, 0);
    check("t5_ready_in_rst", req_ready, 0);
    tick();
    check("t5_write_in_rst", wb_write, 0);
    check("t5_ready_in_rst2", req_ready, 0);
    rst = 1'b0;
    set_req(0, 5'd4, 32'h44);
    #1;
    check("t5_r0_priority", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check("t5_wb_id", wb_id, 0);
    check("t5_wb_write", wb_write, 1);
    tick();

    // 6: write to r0; strobe depends on the zero-guard build option.
`ifdef WB_ZERO_GUARD_EN
    exp_zero_write = 1'b0;
`else
    exp_zero_write = 1'b1;
`endif
    set_req(0, 5'd0, 32'hFFFFFFFF);
    req_valid = 3'b001;
    #1;
    check("t6_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check("t6_wb_write", wb_write, exp_zero_write);
    check("t6_wb_rd", wb_rd, 0);
    check("t6_wb_data", wb_data, 32'hFFFFFFFF);
    tick();
    check("t6_r0", rf[0], exp_zero_write ? 32'hFFFFFFFF : 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
